// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, shifts out one
// 11-bit frame on device-generated clock falls, checks the device ACK, then waits for an idle bus.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 640,
    parameter int TIMEOUT_CYCLES = 131072,
    parameter int FILTER_LEN     = 4
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    // REQ is the last cycle of the inhibit window, so ps2_clk is held low INHIBIT_CYCLES in total.
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [3:0]    STOP_IDX = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          clk_s, data_s, fall;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    frame_q, frame_d;
    logic          dout_q, dout_d;
    logic [1:0]    err_q, err_d;
    logic          done_q, done_d;
    logic          timed_out;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Both pads idle high through their pull-ups, so the synchronisers reset to 1.
    // NOTE: registers are updated with <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign fall      = filt_q & ~filt_d;
    assign timed_out = (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        dout_d  = dout_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                dout_d = 1'b0;
                if (tx_start) begin
                    frame_d = {~^tx_data, tx_data};
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + 4'd1;
                    dout_d = (idx_q == STOP_IDX) ? 1'b0 : ~frame_q[idx_q];
                    if (idx_q == STOP_IDX) begin
                        state_d = S_ACK;
                    end
                end else if (timed_out) begin
                    dout_d  = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        err_d   = ERR_NOACK;
                        state_d = S_ERR;
                    end
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q && data_s) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR: begin
                cnt_d   = '0;
                dout_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                dout_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            dout_q  <= 1'b0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2_data_oe = dout_q;
    assign tx_ready    = (state_q == S_IDLE);
    assign tx_active   = (state_q != S_IDLE);
    assign tx_done     = done_q;
    assign tx_error    = (state_q == S_ERR);
    assign err_code    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model clocks each frame back while the bench
// compares bus bits, pulse timing and error codes against hand-computed values.
module tb_ps2_host_tx;

    localparam int INHIBIT = 640;
    localparam int TIMEOUT = 3000;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready, tx_active, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic glitch_low = 1'b0;

    // Open-drain bus with pull-ups: low whenever anybody drives it.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (4)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit overlap = 1'b0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) overlap = 1'b1;
    end

    task automatic issue_start(input logic [7:0] b);
        @(negedge CLOCK);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge CLOCK);
        tx_start = 1'b0;
    endtask

    // Counts cycles with ps2_clk held low, then lets the deglitch filter see the released line.
    task automatic measure_inhibit(output int len, output int t_rel);
        len = 0;
        while (ps2_clk_oe === 1'b1 && len < 5000) begin
            len++;
            @(negedge CLOCK);
        end
        t_rel = cyc;
        repeat (20) @(negedge CLOCK);
    endtask

    // Keyboard model: ten clock periods, sampling the data line in the high phase of each.
    task automatic shift_frame(input int glitch_at, input int restart_at, input int stop_at,
                               output logic [10:0] bits);
        bits    = '0;
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge CLOCK);
                if (i == restart_at && k == 2) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                    n_tests++;
                    if (tx_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL ready_in_shift: got %b, expected 0", tx_ready);
                    end
                end
                if (i == restart_at && k == 3) tx_start = 1'b0;
                if (i == stop_at && k == 10) return;
            end
            dev_clk_low = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge CLOCK);
                if (i == glitch_at && k == 8) glitch_low = 1'b1;
                if (i == glitch_at && k == 10) glitch_low = 1'b0;
            end
            bits[i] = ps2_data_in;
        end
    endtask

    task automatic wait_end(input int limit, output int which, output int t_end);
        int k;
        which = 0;
        t_end = 0;
        k     = 0;
        while (which == 0 && k < limit) begin
            @(negedge CLOCK);
            k++;
            t_end = cyc;
            if (tx_done === 1'b1) which = 1;
            else if (tx_error === 1'b1) which = 2;
        end
    endtask

    task automatic do_good_transfer(input string name, input logic [7:0] b, input logic par,
                                    input int glitch_at, input int restart_at,
                                    input bit started);
        int len, t_rel, which, t_end, d0, e0;
        logic [10:0] bits, exp_bits;
        d0       = done_cnt;
        e0       = err_cnt;
        exp_bits = {1'b1, par, b, 1'b0};
        if (!started) issue_start(b);
        measure_inhibit(len, t_rel);
        n_tests++;
        if (len != INHIBIT) begin
            n_fail++;
            $display("FAIL %s inhibit_len: got %0d, expected %0d", name, len, INHIBIT);
        end
        shift_frame(glitch_at, restart_at, 0, bits);
        n_tests++;
        if (bits !== exp_bits) begin
            n_fail++;
            $display("FAIL %s frame: got %b, expected %b", name, bits, exp_bits);
        end
        dev_data_low = 1'b1;
        dev_clk_low  = 1'b1;
        repeat (20) @(negedge CLOCK);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        wait_end(200, which, t_end);
        n_tests++;
        if (which != 1) begin
            n_fail++;
            $display("FAIL %s end_kind: got %0d, expected 1 (done)", name, which);
        end
        n_tests++;
        if (err_code !== 2'b00 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end_state: got err_code=%b ready=%b, expected 00 1", name, err_code,
                     tx_ready);
        end
        @(negedge CLOCK);
        n_tests++;
        if (tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got %b, expected 0", name, tx_done);
        end
        repeat (3) @(negedge CLOCK);
        n_tests++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_fail++;
            $display("FAIL %s pulse_counts: got done=%0d err=%0d, expected 1 0", name,
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset();
        @(negedge CLOCK);
        n_tests++;
        if ({tx_ready, tx_active, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe}
            !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 10000000",
                     {tx_ready, tx_active, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe});
        end
        RESET_N = 1'b1;
        repeat (5) @(negedge CLOCK);
        n_tests++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b clk_oe=%b, expected 1 0", tx_ready,
                     ps2_clk_oe);
        end
    endtask

    task automatic test_basic();
        do_good_transfer("ed", 8'hED, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_parity();
        do_good_transfer("par_00", 8'h00, 1'b1, 0, 0, 1'b0);
        do_good_transfer("par_ff", 8'hFF, 1'b1, 0, 0, 1'b0);
        do_good_transfer("par_01", 8'h01, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_no_ack();
        int len, t_rel, which, t_end, d0, e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        issue_start(8'hED);
        measure_inhibit(len, t_rel);
        shift_frame(0, 0, 0, bits);
        dev_clk_low = 1'b1;
        wait_end(100, which, t_end);
        n_tests++;
        if (which != 2) begin
            n_fail++;
            $display("FAIL noack_end_kind: got %0d, expected 2 (error)", which);
        end
        n_tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || err_code !== 2'b10) begin
            n_fail++;
            $display("FAIL noack_state: got clk_oe=%b data_oe=%b err_code=%b, expected 0 0 10",
                     ps2_clk_oe, ps2_data_oe, err_code);
        end
        dev_clk_low = 1'b0;
        repeat (30) @(negedge CLOCK);
        n_tests++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1 || err_code !== 2'b10) begin
            n_fail++;
            $display("FAIL noack_pulses: got done=%0d err=%0d code=%b, expected 0 1 10",
                     done_cnt - d0, err_cnt - e0, err_code);
        end
    endtask

    task automatic test_timeout();
        int len, t_rel, which, t_end, d0;
        d0 = done_cnt;
        issue_start(8'hED);
        measure_inhibit(len, t_rel);
        wait_end(TIMEOUT + 200, which, t_end);
        n_tests++;
        if (which != 2 || t_end - t_rel != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_latency: got kind=%0d cycles=%0d, expected 2 %0d", which,
                     t_end - t_rel, TIMEOUT);
        end
        n_tests++;
        if (err_code !== 2'b01 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL timeout_code: got err_code=%b done=%0d, expected 01 0", err_code,
                     done_cnt - d0);
        end
        repeat (5) @(negedge CLOCK);
    endtask

    task automatic test_back_to_back();
        do_good_transfer("b2b_first", 8'hA5, 1'b1, 0, 3, 1'b0);
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge CLOCK);
        tx_start = 1'b0;
        n_tests++;
        if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got ready=%b clk_oe=%b, expected 0 1", tx_ready,
                     ps2_clk_oe);
        end
        do_good_transfer("b2b_second", 8'h12, 1'b1, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int len, t_rel, d0, e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        issue_start(8'hED);
        measure_inhibit(len, t_rel);
        shift_frame(0, 0, 5, bits);
        n_tests++;
        if (ps2_data_oe !== 1'b1 || tx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL bit4_drive: got data_oe=%b active=%b, expected 1 1", ps2_data_oe,
                     tx_active);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_active !== 1'b0
            || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got clk_oe=%b data_oe=%b active=%b ready=%b, expected 0 0 0 1",
                     ps2_clk_oe, ps2_data_oe, tx_active, tx_ready);
        end
        repeat (3) @(negedge CLOCK);
        dev_clk_low = 1'b0;
        RESET_N     = 1'b1;
        repeat (20) @(negedge CLOCK);
        n_tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got done=%0d err=%0d, expected 0 0", done_cnt - d0,
                     err_cnt - e0);
        end
        do_good_transfer("f4_after_reset", 8'hF4, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_glitch();
        do_good_transfer("glitch", 8'hED, 1'b1, 4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        n_tests++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL done_error_overlap: got %b, expected 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the send-side counterpart of the existing keyboard receiver that decodes scan codes into resetKey/MRESET/scanSW.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, over the shared open-drain ps2_clk/ps2_data lines.
- Runs in the pclk domain next to the keyboard receiver.
- Raises tx_active so the receiver ignores line activity while a command is in flight.

Parameters:
INHIBIT_CYCLES, 640, CLOCK cycles ps2_clk is held low before the request-to-send (≥100 us at pclk).
TIMEOUT_CYCLES, 131072, max CLOCK cycles waiting for any device edge or final idle before aborting.
FILTER_LEN, 4, consecutive equal samples needed to accept a new ps2_clk level (deglitch).

Ports:
CLOCK  in  1  system clock (pclk).
RESET_N  in  1  asynchronous active-low reset.
tx_data  in  8  byte to send; captured on accepted start.
tx_start  in  1  single-cycle request; accepted only when tx_ready=1.
tx_ready  out  1  high in IDLE only.
tx_active  out  1  high from start acceptance until return to IDLE; receiver gating.
tx_done  out  1  one-cycle pulse; transfer ended with valid ACK.
tx_error  out  1  one-cycle pulse; timeout or missing ACK.
err_code  out  2  00 none, 01 timeout, 10 no ACK; held until the next accepted start.
ps2_clk_in  in  1  ps2_clk pad input, asynchronous.
ps2_data_in  in  1  ps2_data pad input, asynchronous.
ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release (pull-up).
ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.

Behaviour:
- Reset, async on RESET_N=0:
  - state IDLE.
  - ps2_clk_oe=0, ps2_data_oe=0.
  - tx_ready=1, tx_active=0, tx_done=0, tx_error=0, err_code=00.
  - counters 0.
  - Applies immediately even mid-transfer; lines are released the same instant.
- Inputs: each pad input passes through a 2-flop synchronizer. ps2_clk then passes through the FILTER_LEN filter; the filtered level changes only after FILTER_LEN equal samples.
- fall = filtered ps2_clk 1→0, one-cycle strobe.
- Start acceptance, in IDLE with tx_start=1:
  - latch tx_data.
  - compute parity = ~^tx_data (odd parity).
  - err_code←00, go INHIBIT.
  - tx_start outside IDLE is ignored (no queueing).
- States:
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then REQ.
  - REQ: data_oe=1 (start bit 0); the next cycle clk_oe=0, go SHIFT with bit index 0, timeout counter cleared.
  - SHIFT: on each fall, drive the next bit. Indexes 0-7 are data LSB first; data_oe = ~bit. Index 8 is parity. Index 9 is stop: data_oe=0. Index increments per fall. After the index-9 fall, go ACK.
  - ACK: on the next fall, sample synced ps2_data. If 0, go WAIT_IDLE. If 1, go ERR with code 10.
  - WAIT_IDLE: wait until filtered clk=1 and synced data=1, then pulse tx_done and go IDLE.
  - ERR: clk_oe=0 and data_oe=0; pulse tx_error one cycle; go IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE the counter increments every cycle and clears on each fall. Reaching TIMEOUT_CYCLES→ERR with code 01. In WAIT_IDLE the counter is not cleared.
- tx_active=1 in every state except IDLE. tx_ready = state==IDLE.
- tx_done and tx_error are never high in the same cycle. Each is asserted exactly once per accepted start, unless reset intervenes.
- A glitch shorter than FILTER_LEN cycles on ps2_clk never generates fall.
- Counter widths are sized to hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Test Plan:
- tx_data=0xED, model keyboard clocks 11 falls (~40 µs period) and pulls data low at fall 11 → clk_oe low exactly 640 cycles. Bits on data line are 0,1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done single pulse, err_code=00, tx_ready returns 1.
- Parity corners: 0x00→parity 1, 0xFF→parity 1, 0x01→parity 0. All other bits check LSB first.
- Model holds data high at ACK fall → tx_error pulse, err_code=10, both oe=0 the next cycle, no tx_done.
- Model never clocks after REQ → tx_error exactly TIMEOUT_CYCLES cycles after clk release, err_code=01.
- tx_start re-pulsed during SHIFT with 0x55 → ignored, original byte completes. A new start accepted right after tx_ready=1 begins INHIBIT.
- RESET_N low during SHIFT bit 4 → oe outputs 0 asynchronously, tx_active=0, no done/error pulse. Next transfer 0xF4 completes correctly.
- 2-cycle low glitch on ps2_clk during SHIFT → bit index unchanged.
